// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
//   XLEN / ILEN      : address and instruction widths
//   DEFAULT_RESET_PC : default first fetch address
//   NOP_INSTR        : canonical no-op encoding (addi x0, x0, 0)
//   fetch_entry_t    : one prefetch queue entry {instr, pc}
//   pc_next / word_align : address helpers shared by the fetch logic
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Sequential word address; wraps from FFFF_FFFC to 0 by plain modulo arithmetic.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  // Redirect targets may carry junk in the low bits; fetch is word-granular.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue of fetch_entry_t.
//   clk     : clock
//   rst_n   : synchronous active-low reset (pointers and count only)
//   i_push  : write i_entry at the tail
//   i_pop   : drop the head entry
//   i_flush : discard all entries; overrides push and pop
//   i_entry : entry to write
//   o_count : number of valid entries, 0..DEPTH
//   o_head  : entry at the head (meaningful only when o_count != 0)
// A pushed entry becomes visible at the head no earlier than the next cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_entry,
  output logic [CW-1:0] o_count,
  output fetch_entry_t  o_head
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Guards keep the pointers coherent even if a caller misbehaves;
  // pushing into a full queue is allowed only when the head leaves the same cycle.
  assign w_do_pop  = i_pop && !w_empty && !i_flush;
  assign w_do_push = i_push && (!w_full || w_do_pop) && !i_flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end.
// Owns the fetch PC, issues one word request per cycle to a 1-cycle-latency
// instruction memory, buffers responses in a prefetch queue and hands
// {instr, pc, pc+4} to IF/EX over valid/ready. EX redirects flush everything.
//   clk            : clock
//   rst_n          : synchronous active-low reset
//   imem_req       : request issued this cycle
//   imem_addr      : word address of the request
//   imem_rdata     : instruction for last cycle's request
//   redirect_valid : taken branch/jump from EX
//   redirect_pc    : new fetch target (low two bits ignored)
//   out_valid      : queue head valid
//   out_ready      : IF/EX accepts the head
//   out_instr      : head instruction
//   out_pc         : head instruction address
//   out_pc_plus4   : out_pc + 4, modulo 2^32
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;

  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_occupancy;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  // Credit check counts queued plus in-flight words against registered state only,
  // so out_ready never reaches imem_req combinationally. A same-cycle pop earns no credit.
  // The sum is at most DEPTH+1, which always fits in CW bits.
  assign w_occupancy = w_count + CW'(r_inflight);
  assign w_issue     = rst_n && !redirect_valid && (w_occupancy < CW'(DEPTH));

  assign imem_req  = w_issue;
  assign imem_addr = rst_n ? r_fetch_pc : RESET_PC;

  // A response is dropped whenever a redirect lands in the cycle it returns.
  assign w_push       = r_inflight && !redirect_valid;
  assign w_push_entry = '{instr: imem_rdata, pc: r_inflight_pc};

  // --- fetch PC and in-flight tracking ---
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= word_align(redirect_pc);
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_fetch_pc    <= pc_next(r_fetch_pc);
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_fetch_pc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  // --- prefetch queue ---
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_entry (w_push_entry),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // --- IF/EX handshake ---
  // The head is hidden during a redirect so no stale instruction is accepted that cycle.
  assign out_valid    = rst_n && (w_count != '0) && !redirect_valid;
  assign w_pop        = out_valid && out_ready;
  assign out_instr    = rst_n ? w_head.instr : '0;
  assign out_pc       = rst_n ? w_head.pc : '0;
  assign out_pc_plus4 = rst_n ? pc_next(w_head.pc) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle stimulus and expected
// outputs covering start-up, stall, redirects, PC wrap and mid-stream reset,
// followed by a hand-written long-stall/drain sequence with a scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] SIG = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
  );

  // 1-cycle-latency memory whose word at address A is A ^ A5A5_0000.
  logic [31:0] r_mem_addr = 32'h0;
  always @(posedge clk) r_mem_addr <= imem_addr;
  assign imem_rdata = r_mem_addr ^ SIG;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    rst_n          = r;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instr, pc ^ SIG);
    chk({tag, "_pc4"}, out_pc_plus4, pc + 32'd4);
  endtask

  logic [31:0] exp_out;
  logic [31:0] exp_req;

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

    //                rst   rdy   rv    rpc           req   addr          vld   pc
    tv.push_back(vec_t'{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0});
    tv.push_back(vec_t'{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h4});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'h8});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h14,       1'b1, 32'hC});
    // stall two cycles: queue builds to 3 entries with one in flight
    tv.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h18,       1'b1, 32'h10});
    tv.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1C,       1'b1, 32'h10});
    // redirect to unaligned 0x103
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b1, 32'h103,      1'b0, 32'h20,       1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100,      1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h104,      1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h108,      1'b1, 32'h100});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h10C,      1'b1, 32'h104});
    // back-to-back redirects: 0x200 then 0x300
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b1, 32'h200,      1'b0, 32'h110,      1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b1, 32'h300,      1'b0, 32'h200,      1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h300,      1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h304,      1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h308,      1'b1, 32'h300});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h30C,      1'b1, 32'h304});
    // redirect near the top of the address space
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h310,     1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'hFFFF_FFF8});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'hFFFF_FFFC});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0});
    // one-cycle reset with the fetch of 0x8 in flight
    tv.push_back(vec_t'{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0});
    tv.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h4});

    foreach (tv[i]) begin
      drive(tv[i].rst_n, tv[i].rdy, tv[i].rv, tv[i].rpc);
      chk($sformatf("row%0d_req", i), {31'b0, imem_req}, {31'b0, tv[i].e_req});
      chk($sformatf("row%0d_addr", i), imem_addr, tv[i].e_addr);
      chk($sformatf("row%0d_valid", i), {31'b0, out_valid}, {31'b0, tv[i].e_valid});
      if (tv[i].e_valid)
        chk_head($sformatf("row%0d", i), tv[i].e_pc);
      else if (!tv[i].rst_n) begin
        chk($sformatf("row%0d_rst_instr", i), out_instr, 32'h0);
        chk($sformatf("row%0d_rst_pc", i), out_pc, 32'h0);
        chk($sformatf("row%0d_rst_pc4", i), out_pc_plus4, 32'h0);
      end
      tick();
    end

    // Long stall from the first cycle out of reset, then drain.
    drive(1'b0, 1'b0, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0); tick();
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      chk($sformatf("stall%0d_req", c), {31'b0, imem_req}, {31'b0, (c < 4)});
      if (c < 4) chk($sformatf("stall%0d_addr", c), imem_addr, 32'(c * 4));
      chk($sformatf("stall%0d_valid", c), {31'b0, out_valid}, {31'b0, (c >= 2)});
      if (c >= 2) chk_head($sformatf("stall%0d", c), 32'h0);
      tick();
    end

    exp_out = 32'h0;
    exp_req = 32'h10;
    for (int c = 0; c < 40 && exp_out != 32'h30; c++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      if (c == 0) chk("release_req", {31'b0, imem_req}, 32'h0);
      if (c == 1) chk("resume_req", {31'b0, imem_req}, 32'h1);
      if (imem_req) begin
        chk($sformatf("drain%0d_reqaddr", c), imem_addr, exp_req);
        exp_req = exp_req + 32'd4;
      end
      if (out_valid) begin
        chk_head($sformatf("drain%0d", c), exp_out);
        exp_out = exp_out + 32'd4;
      end
      tick();
    end
    chk("drain_complete", exp_out, 32'h30);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
